// File: rtl/muldiv_issue_ctrl.sv
// muldiv_issue_ctrl: one-at-a-time sequencer between execute-stage issue and
// the RV32M MULDIV unit. Holds operands on the MULDIV inputs, pulses start for
// division-class ops, waits for busy to fall and returns the captured result
// with its destination index to writeback.
module muldiv_issue_ctrl #(
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [2:0]      req_funct3,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic [31:0]     md_rs1,
    output logic [31:0]     md_rs2,
    output logic [2:0]      md_funct3,
    output logic            md_start,
    output logic            md_rstLow,
    input  logic [31:0]     md_c_out,
    input  logic            md_busy,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_data,
    output logic [RD_W-1:0] wb_rd
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     md_rs1_q, md_rs1_d;
    logic [31:0]     md_rs2_q, md_rs2_d;
    logic [2:0]      md_funct3_q, md_funct3_d;
    logic [31:0]     wb_data_q, wb_data_d;
    logic [RD_W-1:0] wb_rd_q, wb_rd_d;
    logic            abort_q, abort_d;

    // State register and datapath flops, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            md_rs1_q    <= '0;
            md_rs2_q    <= '0;
            md_funct3_q <= '0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            md_rs1_q    <= md_rs1_d;
            md_rs2_q    <= md_rs2_d;
            md_funct3_q <= md_funct3_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            abort_q     <= abort_d;
        end
    end

    // Next-state logic; a flush outside IDLE overrides every other transition.
    always_comb begin
        state_d     = state_q;
        md_rs1_d    = md_rs1_q;
        md_rs2_d    = md_rs2_q;
        md_funct3_d = md_funct3_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        abort_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Operands only move here, so MULDIV's previous-operand
                // compare remains meaningful across consecutive ops.
                if (req_valid) begin
                    md_rs1_d    = req_rs1;
                    md_rs2_d    = req_rs2;
                    md_funct3_d = req_funct3;
                    wb_rd_d     = req_rd;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // Busy is not yet meaningful on the start cycle.
                if (!md_funct3_q[2]) begin
                    wb_data_d = md_c_out;
                    state_d   = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Special cases never raise busy and complete on the first look.
                if (!md_busy) begin
                    wb_data_d = md_c_out;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush && (state_q != IDLE)) begin
            state_d   = IDLE;
            wb_data_d = wb_data_q;
            abort_d   = 1'b1;
        end
    end

    // Start is pulsed for every division-class op; MULDIV itself decides
    // whether the op needs the iterative divider.
    assign md_start  = (state_q == ISSUE) && md_funct3_q[2];
    assign md_rstLow = !(rst | abort_q);
    assign req_ready = (state_q == IDLE);
    assign wb_valid  = (state_q == DONE);
    assign md_rs1    = md_rs1_q;
    assign md_rs2    = md_rs2_q;
    assign md_funct3 = md_funct3_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;

endmodule
